// File: rtl/mem_arbiter_pkg.sv
// Shared types and byte-lane helpers for the instruction/data memory arbiter.
// Pure declarations and functions; no latency, no flow control.
package mem_arbiter_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_IFETCH = 2'd1,
        ST_DATA   = 2'd2,
        ST_ERR    = 2'd3
    } arb_state_t;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } grant_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    function automatic logic [XLEN-1:0] sext8(input logic [7:0] b);
        return {{(XLEN-8){b[7]}}, b};
    endfunction

    function automatic logic [XLEN-1:0] zext8(input logic [7:0] b);
        return {{(XLEN-8){1'b0}}, b};
    endfunction

    function automatic logic [XLEN-1:0] sext16(input logic [15:0] h);
        return {{(XLEN-16){h[15]}}, h};
    endfunction

    function automatic logic [XLEN-1:0] zext16(input logic [15:0] h);
        return {{(XLEN-16){1'b0}}, h};
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            F3_B:    return 4'b0001 << off;
            F3_H:    return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] store_rep(input logic [2:0] f3, input logic [XLEN-1:0] d);
        case (f3)
            F3_B:    return {4{d[7:0]}};
            F3_H:    return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    // Undefined encodings are folded into the misaligned path so they never reach memory.
    function automatic logic is_misaligned(input logic we, input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            F3_B:    return 1'b0;
            F3_H:    return off[0];
            F3_W:    return off != 2'b00;
            F3_BU:   return we;
            F3_HU:   return we | off[0];
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: store byte enables/replication, load shift/extend, misalign detect.
// Zero latency; no flow control.
module mem_lane_align
    import mem_arbiter_pkg::*;
(
    input  logic            we,
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] rdata_raw,
    output logic [3:0]      be,
    output logic [XLEN-1:0] wdata_rep,
    output logic [XLEN-1:0] rdata_ext,
    output logic            misaligned
);

    logic [XLEN-1:0] shifted;

    always_comb begin
        be         = we ? store_be(funct3, addr_lo) : 4'b1111;
        wdata_rep  = store_rep(funct3, wdata);
        misaligned = is_misaligned(we, funct3, addr_lo);
        shifted    = rdata_raw >> {addr_lo, 3'b000};
        case (funct3)
            F3_B:    rdata_ext = sext8(shifted[7:0]);
            F3_BU:   rdata_ext = zext8(shifted[7:0]);
            F3_H:    rdata_ext = sext16(shifted[15:0]);
            F3_HU:   rdata_ext = zext16(shifted[15:0]);
            default: rdata_ext = rdata_raw;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and load/store onto one memory port; request-to-valid >= 2 cycles, waits on m_ack.
// Data has priority with a starvation limit for fetch; MEM_ARB_RR_EN selects round-robin instead.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int I_STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_req,
    input  logic [XLEN-1:0] i_addr,
    output logic [XLEN-1:0] i_rdata,
    output logic            i_valid,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [2:0]      d_funct3,
    input  logic [XLEN-1:0] d_addr,
    input  logic [XLEN-1:0] d_wdata,
    output logic [XLEN-1:0] d_rdata,
    output logic            d_valid,
    output logic            d_err,
    output logic            m_req,
    output logic            m_we,
    output logic [XLEN-1:0] m_addr,
    output logic [3:0]      m_be,
    output logic [XLEN-1:0] m_wdata,
    input  logic [XLEN-1:0] m_rdata,
    input  logic            m_ack
);

    arb_state_t      state_q, state_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [3:0]      be_q, be_d;
    logic            we_q, we_d;
    logic [2:0]      f3_q, f3_d;
    logic [XLEN-1:0] i_rdata_q, i_rdata_d;
    logic [XLEN-1:0] d_rdata_q, d_rdata_d;
    logic            i_valid_q, i_valid_d;
    logic            d_valid_q, d_valid_d;
    logic            d_err_q, d_err_d;

    logic            idle;
    logic            gnt_i, gnt_d;
    logic            lane_we;
    logic [2:0]      lane_f3;
    logic [1:0]      lane_off;
    logic [3:0]      lane_be;
    logic [XLEN-1:0] lane_wdata;
    logic [XLEN-1:0] lane_rdata;
    logic            lane_mis;

    assign idle = (state_q == ST_IDLE);

    // In IDLE the lane logic looks at the incoming request; otherwise at the latched one.
    assign lane_we  = idle ? d_we         : we_q;
    assign lane_f3  = idle ? d_funct3     : f3_q;
    assign lane_off = idle ? d_addr[1:0]  : addr_q[1:0];

    mem_lane_align u_lane (
        .we         (lane_we),
        .funct3     (lane_f3),
        .addr_lo    (lane_off),
        .wdata      (d_wdata),
        .rdata_raw  (m_rdata),
        .be         (lane_be),
        .wdata_rep  (lane_wdata),
        .rdata_ext  (lane_rdata),
        .misaligned (lane_mis)
    );

`ifdef MEM_ARB_RR_EN
    grant_t last_q, last_d;

    assign gnt_i = i_req & (~d_req | (last_q == GNT_D));
    assign gnt_d = d_req & ~gnt_i;

    always_comb begin
        last_d = last_q;
        if (idle && gnt_i) begin
            last_d = GNT_I;
        end else if (idle && gnt_d) begin
            last_d = GNT_D;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= GNT_I;
        end else begin
            last_q <= last_d;
        end
    end
`else
    localparam logic [7:0] STARVE_LIM = 8'(I_STARVE_LIMIT);

    logic [7:0] starve_q, starve_d;

    assign gnt_i = i_req & (~d_req | (starve_q == STARVE_LIM));
    assign gnt_d = d_req & ~gnt_i;

    always_comb begin
        starve_d = starve_q;
        if (idle && gnt_i) begin
            starve_d = 8'd0;
        end else if (idle && gnt_d && i_req && (starve_q != STARVE_LIM)) begin
            starve_d = starve_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= 8'd0;
        end else begin
            starve_q <= starve_d;
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        we_d      = we_q;
        f3_d      = f3_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        i_valid_d = 1'b0;
        d_valid_d = 1'b0;
        d_err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (gnt_d) begin
                    addr_d  = d_addr;
                    we_d    = d_we;
                    f3_d    = d_funct3;
                    be_d    = lane_be;
                    wdata_d = lane_wdata;
                    state_d = lane_mis ? ST_ERR : ST_DATA;
                end else if (gnt_i) begin
                    addr_d  = i_addr;
                    we_d    = 1'b0;
                    be_d    = 4'b1111;
                    state_d = ST_IFETCH;
                end
            end
            ST_IFETCH: begin
                if (m_ack) begin
                    i_rdata_d = m_rdata;
                    i_valid_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (m_ack) begin
                    d_rdata_d = we_q ? d_rdata_q : lane_rdata;
                    d_valid_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            ST_ERR: begin
                d_valid_d = 1'b1;
                d_err_d   = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            we_q      <= 1'b0;
            f3_q      <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            i_valid_q <= 1'b0;
            d_valid_q <= 1'b0;
            d_err_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            we_q      <= we_d;
            f3_q      <= f3_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            i_valid_q <= i_valid_d;
            d_valid_q <= d_valid_d;
            d_err_q   <= d_err_d;
        end
    end

    assign m_req   = (state_q == ST_IFETCH) || (state_q == ST_DATA);
    assign m_we    = m_req & we_q;
    assign m_addr  = {addr_q[XLEN-1:2], 2'b00};
    assign m_be    = be_q;
    assign m_wdata = wdata_q;
    assign i_rdata = i_rdata_q;
    assign i_valid = i_valid_q;
    assign d_rdata = d_rdata_q;
    assign d_valid = d_valid_q;
    assign d_err   = d_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, stores, loads, error path, arbitration and reset abort.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic [31:0] i_rdata;
    logic        i_valid;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [2:0]  d_funct3 = '0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [31:0] d_rdata;
    logic        d_valid;
    logic        d_err;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [3:0]  m_be;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata = '0;
    logic        m_ack;
    logic        auto_ack = 1'b0;
    logic        man_ack = 1'b0;

    int checks = 0;
    int errors = 0;

    // Memory model: either acknowledges in the first cycle of m_req or under manual control.
    assign m_ack = auto_ack ? m_req : man_ack;

    always #5 clk = ~clk;

    mem_arbiter #(.I_STARVE_LIMIT(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_rdata  (i_rdata),
        .i_valid  (i_valid),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_funct3 (d_funct3),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_rdata  (d_rdata),
        .d_valid  (d_valid),
        .d_err    (d_err),
        .m_req    (m_req),
        .m_we     (m_we),
        .m_addr   (m_addr),
        .m_be     (m_be),
        .m_wdata  (m_wdata),
        .m_rdata  (m_rdata),
        .m_ack    (m_ack)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({i_valid, d_valid, d_err, m_req, m_we, m_be} !== 9'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b required 0", {i_valid, d_valid, d_err, m_req, m_we, m_be});
        end
        checks++;
        if ({m_addr, m_wdata, i_rdata, d_rdata} !== 128'b0) begin
            errors++;
            $display("FAIL reset_data: got %h required 0", {m_addr, m_wdata, i_rdata, d_rdata});
        end
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_fetch;
        i_req = 1'b1; i_addr = 32'h100; m_rdata = 32'h0000_0013; auto_ack = 1'b1;
        tick;
        checks++;
        if (m_req !== 1'b1 || m_we !== 1'b0 || m_addr !== 32'h100) begin
            errors++;
            $display("FAIL fetch_issue: got req=%b we=%b addr=%h required 1 0 00000100", m_req, m_we, m_addr);
        end
        i_req = 1'b0;
        tick;
        checks++;
        if (i_valid !== 1'b1 || i_rdata !== 32'h0000_0013 || m_req !== 1'b0) begin
            errors++;
            $display("FAIL fetch_valid: got v=%b data=%h req=%b required 1 00000013 0", i_valid, i_rdata, m_req);
        end
        tick;
        checks++;
        if (i_valid !== 1'b0) begin
            errors++;
            $display("FAIL fetch_pulse: got i_valid=%b required 0", i_valid);
        end
        auto_ack = 1'b0;
    endtask

    task automatic test_ack_idle;
        man_ack = 1'b1;
        tick;
        tick;
        checks++;
        if (m_req !== 1'b0 || i_valid !== 1'b0 || d_valid !== 1'b0) begin
            errors++;
            $display("FAIL ack_idle: got req=%b iv=%b dv=%b required 0 0 0", m_req, i_valid, d_valid);
        end
        man_ack = 1'b0;
    endtask

    task automatic test_stores;
        logic [2:0]  f3 [5];
        logic [31:0] ad [5];
        logic [31:0] wd [5];
        logic [3:0]  xbe [5];
        logic [31:0] xwd [5];
        f3  = '{3'b000, 3'b000, 3'b001, 3'b001, 3'b010};
        ad  = '{32'h203, 32'h101, 32'h202, 32'h000, 32'h300};
        wd  = '{32'h1234_56AB, 32'h0000_0055, 32'hCAFE_BEEF, 32'h0000_1234, 32'h89AB_CDEF};
        xbe = '{4'b1000, 4'b0010, 4'b1100, 4'b0011, 4'b1111};
        xwd = '{32'hABAB_ABAB, 32'h5555_5555, 32'hBEEF_BEEF, 32'h1234_1234, 32'h89AB_CDEF};
        for (int k = 0; k < 5; k++) begin
            d_req = 1'b1; d_we = 1'b1; d_funct3 = f3[k]; d_addr = ad[k]; d_wdata = wd[k];
            tick;
            checks++;
            if (m_req !== 1'b1 || m_we !== 1'b1 || m_addr !== {ad[k][31:2], 2'b00}) begin
                errors++;
                $display("FAIL store_issue[%0d]: got req=%b we=%b addr=%h", k, m_req, m_we, m_addr);
            end
            checks++;
            if (m_be !== xbe[k] || m_wdata !== xwd[k]) begin
                errors++;
                $display("FAIL store_lanes[%0d]: got be=%b wdata=%h required be=%b wdata=%h",
                         k, m_be, m_wdata, xbe[k], xwd[k]);
            end
            d_req = 1'b0;
            tick;
            checks++;
            if (m_req !== 1'b1 || d_valid !== 1'b0) begin
                errors++;
                $display("FAIL store_wait[%0d]: got req=%b dv=%b required 1 0", k, m_req, d_valid);
            end
            man_ack = 1'b1;
            tick;
            man_ack = 1'b0;
            checks++;
            if (d_valid !== 1'b1 || d_err !== 1'b0 || m_req !== 1'b0) begin
                errors++;
                $display("FAIL store_done[%0d]: got dv=%b err=%b req=%b required 1 0 0", k, d_valid, d_err, m_req);
            end
        end
        tick;
    endtask

    task automatic test_loads;
        logic [2:0]  f3 [6];
        logic [31:0] ad [6];
        logic [31:0] rd [6];
        logic [31:0] ex [6];
        f3 = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000};
        ad = '{32'h201, 32'h201, 32'h002, 32'h002, 32'h004, 32'h000};
        rd = '{32'h1234_80FF, 32'h1234_80FF, 32'h8001_1234, 32'h8001_1234, 32'hDEAD_BEEF, 32'h0000_007F};
        ex = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_8001, 32'hDEAD_BEEF, 32'h0000_007F};
        auto_ack = 1'b1;
        for (int k = 0; k < 6; k++) begin
            d_req = 1'b1; d_we = 1'b0; d_funct3 = f3[k]; d_addr = ad[k]; d_wdata = '0; m_rdata = rd[k];
            tick;
            checks++;
            if (m_req !== 1'b1 || m_we !== 1'b0 || m_be !== 4'hF || m_addr !== {ad[k][31:2], 2'b00}) begin
                errors++;
                $display("FAIL load_issue[%0d]: got req=%b we=%b be=%b addr=%h", k, m_req, m_we, m_be, m_addr);
            end
            d_req = 1'b0;
            tick;
            checks++;
            if (d_valid !== 1'b1 || d_err !== 1'b0 || d_rdata !== ex[k]) begin
                errors++;
                $display("FAIL load_data[%0d]: got dv=%b err=%b data=%h required 1 0 %h",
                         k, d_valid, d_err, d_rdata, ex[k]);
            end
        end
        auto_ack = 1'b0;
        tick;
    endtask

    task automatic test_misaligned;
        logic        we [7];
        logic [2:0]  f3 [7];
        logic [31:0] ad [7];
        we = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        f3 = '{3'b010, 3'b001, 3'b101, 3'b010, 3'b001, 3'b011, 3'b100};
        ad = '{32'h202, 32'h201, 32'h003, 32'h001, 32'h003, 32'h000, 32'h000};
        man_ack = 1'b1;
        for (int k = 0; k < 7; k++) begin
            d_req = 1'b1; d_we = we[k]; d_funct3 = f3[k]; d_addr = ad[k]; d_wdata = 32'hFFFF_FFFF;
            tick;
            checks++;
            if (m_req !== 1'b0 || d_valid !== 1'b0) begin
                errors++;
                $display("FAIL err_cycle1[%0d]: got req=%b dv=%b required 0 0", k, m_req, d_valid);
            end
            d_req = 1'b0;
            tick;
            checks++;
            if (d_valid !== 1'b1 || d_err !== 1'b1 || m_req !== 1'b0) begin
                errors++;
                $display("FAIL err_done[%0d]: got dv=%b err=%b req=%b required 1 1 0", k, d_valid, d_err, m_req);
            end
            tick;
            checks++;
            if (d_valid !== 1'b0 || d_err !== 1'b0 || m_req !== 1'b0) begin
                errors++;
                $display("FAIL err_clear[%0d]: got dv=%b err=%b req=%b required 0 0 0", k, d_valid, d_err, m_req);
            end
        end
        man_ack = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic exp_i;
        int   n;
        i_req = 1'b1; i_addr = 32'h400;
        d_req = 1'b1; d_we = 1'b0; d_funct3 = 3'b010; d_addr = 32'h800; m_rdata = '0;
        auto_ack = 1'b1;
        for (int k = 0; k < 10; k++) begin
            n = 0;
            tick;
            while (m_req !== 1'b1 && n < 4) begin
                tick;
                n++;
            end
`ifdef MEM_ARB_RR_EN
            exp_i = (k % 2) == 1;
`else
            exp_i = (k % 5) == 4;
`endif
            checks++;
            if (m_req !== 1'b1) begin
                errors++;
                $display("FAIL arb_timeout[%0d]: got m_req=%b required 1", k, m_req);
            end else if (m_addr !== (exp_i ? 32'h400 : 32'h800)) begin
                errors++;
                $display("FAIL arb_order[%0d]: got addr=%h required %h", k, m_addr, exp_i ? 32'h400 : 32'h800);
            end
        end
        i_req = 1'b0; d_req = 1'b0;
        tick;
        auto_ack = 1'b0;
        tick;
    endtask

    task automatic test_reset_inflight;
        logic seen;
        d_req = 1'b1; d_we = 1'b0; d_funct3 = 3'b010; d_addr = 32'h10; m_rdata = 32'h5A5A_5A5A;
        tick;
        checks++;
        if (m_req !== 1'b1 || m_addr !== 32'h10) begin
            errors++;
            $display("FAIL abort_issue: got req=%b addr=%h required 1 00000010", m_req, m_addr);
        end
        d_req = 1'b0;
        tick;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (m_req !== 1'b0 || m_addr !== 32'h0 || m_be !== 4'h0 || d_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_async: got req=%b addr=%h be=%b dv=%b required all 0", m_req, m_addr, m_be, d_valid);
        end
        man_ack = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick;
            if (d_valid !== 1'b0 || m_req !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL abort_late_ack: got activity=%b required 0", seen);
        end
        man_ack = 1'b0;
    endtask

    initial begin
        test_reset;
        test_fetch;
        test_ack_idle;
        test_stores;
        test_loads;
        test_misaligned;
        test_reset;
        test_back_to_back;
        test_reset_inflight;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
